// File: rtl/data_mem_ctrl.sv
// Load/store controller between the MEM stage and a word-organised data RAM.
// Does sub-word load extension and read-modify-write for byte/halfword stores.
module data_mem_ctrl #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t      state_reg;
  logic [1:0]  size_reg;
  logic        ld_unsigned_reg;
  logic [1:0]  lane_reg;
  logic [15:0] wdata_reg;
  logic [31:0] wbuf_reg;
  logic [31:0] rdata_reg;
  logic [31:0] ram_addr_reg;
  logic        resp_valid_reg;
  logic        err_reg;
  logic        ram_ce_reg;
  logic        ram_we_reg;

  logic        req_err;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] ld_data;
  logic [4:0]  lane_shift;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] st_merge;

  assign req_ready  = (state_reg == IDLE) & rst_n;
  assign resp_valid = resp_valid_reg;
  assign rdata      = rdata_reg;
  assign err        = err_reg;
  assign ram_ce     = ram_ce_reg;
  assign ram_we     = ram_we_reg;
  assign ram_addr   = ram_addr_reg;
  assign ram_wdata  = wbuf_reg;

  // Without alignment checking, halves use addr[1] only and words ignore addr[1:0].
  assign req_err = (size == 2'b11) |
                   (ALIGN_CHECK & (((size == 2'b01) & addr[0]) |
                                   ((size == 2'b10) & (addr[1:0] != 2'b00))));

  always_comb begin
    byte_val = ram_rdata[7:0];
    case (lane_reg)
      2'd1:    byte_val = ram_rdata[15:8];
      2'd2:    byte_val = ram_rdata[23:16];
      2'd3:    byte_val = ram_rdata[31:24];
      default: byte_val = ram_rdata[7:0];
    endcase
    half_val = lane_reg[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_reg)
      2'b00:   ld_data = {{24{~ld_unsigned_reg & byte_val[7]}}, byte_val};
      2'b01:   ld_data = {{16{~ld_unsigned_reg & half_val[15]}}, half_val};
      default: ld_data = ram_rdata;
    endcase
  end

  // Splice the store data into the word just read for the RMW write-back.
  always_comb begin
    if (size_reg == 2'b00) begin
      lane_shift = {lane_reg, 3'b000};
      lane_mask  = 32'h0000_00FF << lane_shift;
      lane_data  = {24'h0, wdata_reg[7:0]} << lane_shift;
    end else begin
      lane_shift = {lane_reg[1], 4'b0000};
      lane_mask  = 32'h0000_FFFF << lane_shift;
      lane_data  = {16'h0, wdata_reg} << lane_shift;
    end
    st_merge = (ram_rdata & ~lane_mask) | lane_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      size_reg        <= 2'b00;
      ld_unsigned_reg <= 1'b0;
      lane_reg        <= 2'b00;
      wdata_reg       <= 16'h0;
      wbuf_reg        <= 32'h0;
      rdata_reg       <= 32'h0;
      ram_addr_reg    <= 32'h0;
      resp_valid_reg  <= 1'b0;
      err_reg         <= 1'b0;
      ram_ce_reg      <= 1'b0;
      ram_we_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready) begin
            size_reg        <= size;
            ld_unsigned_reg <= ld_unsigned;
            lane_reg        <= addr[1:0];
            wdata_reg       <= wdata[15:0];
            ram_addr_reg    <= {addr[31:2], 2'b00};
            if (req_err) begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              err_reg        <= 1'b1;
              rdata_reg      <= 32'h0;
            end else if (!is_store) begin
              state_reg  <= RD;
              ram_ce_reg <= 1'b1;
            end else if (size == 2'b10) begin
              state_reg  <= WR;
              wbuf_reg   <= wdata;
              ram_ce_reg <= 1'b1;
              ram_we_reg <= 1'b1;
            end else begin
              state_reg  <= RMW_RD;
              ram_ce_reg <= 1'b1;
            end
          end
        end
        RD: begin
          state_reg      <= RESP;
          rdata_reg      <= ld_data;
          ram_ce_reg     <= 1'b0;
          resp_valid_reg <= 1'b1;
        end
        RMW_RD: begin
          state_reg  <= WR;
          wbuf_reg   <= st_merge;
          ram_we_reg <= 1'b1;
        end
        WR: begin
          state_reg      <= RESP;
          ram_ce_reg     <= 1'b0;
          ram_we_reg     <= 1'b0;
          resp_valid_reg <= 1'b1;
        end
        RESP: begin
          state_reg      <= IDLE;
          resp_valid_reg <= 1'b0;
          err_reg        <= 1'b0;
          rdata_reg      <= 32'h0;
        end
        default: begin
          state_reg  <= IDLE;
          ram_ce_reg <= 1'b0;
          ram_we_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Load/store controller that sits between the MiniSys MEM pipeline stage and the word-organised data RAM; it is the initiator side of the RAM's ce/we/addr/data_in/data_out port. It accepts one byte, halfword or word request at a time over a valid/ready handshake. It performs sign/zero extension for loads and read-modify-write for sub-word stores, because the RAM only writes whole words. It flags misaligned or illegal accesses without touching memory.

## Interface
- ALIGN_CHECK, 1: 1 = misaligned half/word access returns err; 0 = low address bits are forced to natural alignment and the access proceeds.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; = (state==IDLE) & rst_n.
- is_store  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- ld_unsigned  in  1  1 = zero-extend sub-word load, 0 = sign-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
- err  out  1  valid with resp_valid; 1 = misaligned or illegal size.
- ram_ce  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM byte address, bits [1:0] always 00.
- ram_wdata  out  32  full word to write.
- ram_rdata  in  32  RAM combinational read data (valid while ram_ce=1, ram_we=0).

## Operation
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE: on req_valid & req_ready at a rising edge, latch is_store/size/ld_unsigned/addr/wdata. Next state:
  - error (size==11, or ALIGN_CHECK=1 with half & addr[0]!=0 or word & addr[1:0]!=0) -> RESP with err=1;
  - load -> RD;
  - word store -> WR with wbuf=wdata;
  - byte/half store -> RMW_RD.
- RD: ram_ce=1, ram_we=0. At edge, rdata <= extracted lane, extended per ld_unsigned -> RESP.
- RMW_RD: ram_ce=1, ram_we=0. At edge, wbuf <= ram_rdata with the target lane replaced by wdata[7:0] or wdata[15:0] -> WR.
- WR: ram_ce=1, ram_we=1, ram_wdata=wbuf. The RAM writes at this edge -> RESP.
- RESP: resp_valid=1, req_ready=0 -> IDLE. No backpressure on responses.
- Lanes are little-endian:
  - byte k = addr[1:0] occupies bits [8k+7:8k];
  - half at addr[1]=0 is [15:0], at addr[1]=1 is [31:16].
- ram_addr = {latched addr[31:2], 2'b00} in every state. ram_ce=ram_we=0 in IDLE and RESP.
- Error path issues no RAM cycle; rdata=0, err=1.
- ALIGN_CHECK=0: half uses addr[1] only, word ignores addr[1:0]; err only for size==11.

## Timing
- Reset values (async, immediate):
  - state IDLE;
  - resp_valid, err, ram_ce, ram_we = 0;
  - rdata, ram_wdata, ram_addr, wbuf = 0;
  - req_ready = 0 while rst_n low, 1 after release.
- Latency, with the acceptance edge as cycle 0 and resp_valid high during cycle N:
  - error N=1;
  - load N=2;
  - word store N=2;
  - byte/half store N=3.
- Throughput: next request accepted at the edge ending RESP+1, i.e. in IDLE only. Back-to-back requests have one IDLE cycle between RESP and the next acceptance.
- req_valid while not ready is ignored; the requester holds it.
- Reset mid-operation: state returns to IDLE asynchronously and ram_ce/ram_we drop without waiting for clk. RAM is unmodified unless the WR edge already occurred. An RMW abandoned in RMW_RD leaves memory unchanged.
- All RAM control outputs are state-decoded registers/decodes, glitch-free relative to clk.

## Test plan
- Word store then load: SW addr 0x10, wdata 0xDEADBEEF.
  - Required: ram_we=1 for exactly one cycle, resp at cycle 2.
  - LW 0x10 then returns rdata=0xDEADBEEF, err=0, at cycle 2.
- Sub-word RMW: word 0x11223344 at 0x20; SB addr 0x21, wdata 0xAA.
  - Required: RMW_RD, WR, resp at cycle 3; memory word 0x1122AA44.
  - Then SH addr 0x22, wdata 0x5566 gives 0x5566AA44.
- Load extension: word 0x80FF7F01 at 0x30.
  - LB 0x32 -> 0xFFFFFFFF; LBU 0x32 -> 0x000000FF.
  - LH 0x32 -> 0xFFFF80FF; LHU 0x30 -> 0x00007F01.
- Errors, ALIGN_CHECK=1:
  - LW 0x31, SH 0x23 and size=11: each gives err=1, rdata=0 and resp at cycle 1, with ram_ce never asserted.
  - ALIGN_CHECK=0: LW 0x31 reads word 0x30.
- Reset mid-RMW: SB 0x40 accepted, rst_n pulled low during RMW_RD.
  - Required: ram_ce/ram_we drop within the same cycle and word 0x40 is unchanged.
  - After release, req_ready=1 and the next request completes normally.
